// File: rtl/audio_stereo_out.sv
// -----------------------------------------------------------------------------
// audio_stereo_out
//
// Stereo 1-bit audio output stage. Packed left/right PCM sample pairs are
// written through a strobe into a small FIFO. One pair is popped per PWM frame
// and converted into two PWM bitstreams that drive external RC filters.
//
// Handshake: stereo_pcm_rdy is a plain write strobe. Every clk_audio cycle with
// stereo_pcm_rdy=1 and fifo_full=0 pushes one pair. A strobe while full is
// dropped silently. There is no back-pressure other than fifo_full.
//
// Ports
//   clk_audio      in   sole clock, rising edge
//   aclr           in   async reset, active-low; release is synchronised inside
//   stereo_pcm     in   {left, right} unsigned samples, PCM_W bits each
//   stereo_pcm_rdy in   write strobe, one sample pair per high cycle
//   clk_pcm        in   legacy tie-off, ignored (single-clock design)
//   fifo_full      out  registered, 1 when the FIFO holds FIFO_DEPTH entries
//   left           out  registered left PWM bitstream
//   right          out  registered right PWM bitstream
// -----------------------------------------------------------------------------
module audio_stereo_out #(
    parameter int PCM_W      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk_audio,
    input  logic               aclr,
    input  logic [2*PCM_W-1:0] stereo_pcm,
    input  logic               stereo_pcm_rdy,
    input  logic               clk_pcm,
    output logic               fifo_full,
    output logic               left,
    output logic               right
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PCM_W-1:0] CNT_ONE = {{(PCM_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);

    // clk_pcm is kept only for pin compatibility with older boards.
    logic unused_clk_pcm;
    assign unused_clk_pcm = clk_pcm;

    // Reset release synchroniser: assertion is immediate, release takes two
    // clocks, so the datapath starts on the third edge after aclr rises.
    logic [1:0] sync_q;
    logic       run;

    always_ff @(posedge clk_audio or negedge aclr) begin
        if (!aclr) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign run = sync_q[1];

    // State
    logic [2*PCM_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               full_q, full_d;
    logic [PCM_W-1:0]   cnt_q, cnt_d;
    logic [PCM_W-1:0]   l_q, l_d;
    logic [PCM_W-1:0]   r_q, r_d;
    logic               left_q, left_d;
    logic               right_q, right_d;

    logic [AW:0]        count;
    logic [AW:0]        count_d;
    logic               push;
    logic               pop;
    logic               boundary;
    logic [2*PCM_W-1:0] head;

    // Extra wrap bit on each pointer makes the difference the exact fill level.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign boundary = (cnt_q == {PCM_W{1'b1}});
    assign head     = mem[rd_ptr_q[AW-1:0]];

    // Emptiness is judged before this cycle's push, so a pair written on the
    // boundary cycle into an empty FIFO waits for the next boundary.
    assign push = run && stereo_pcm_rdy && !full_q;
    assign pop  = run && boundary && (count != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count;
        cnt_d    = cnt_q;
        l_d      = l_q;
        r_d      = r_q;
        left_d   = 1'b0;
        right_d  = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            l_d      = head[2*PCM_W-1:PCM_W];
            r_d      = head[PCM_W-1:0];
        end
        count_d = wr_ptr_d - rd_ptr_d;

        if (run) begin
            cnt_d   = cnt_q + CNT_ONE;
            left_d  = (cnt_q < l_q);
            right_d = (cnt_q < r_q);
        end
    end

    assign full_d = (count_d == DEPTH_C);

    always_ff @(posedge clk_audio or negedge aclr) begin
        if (!aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            cnt_q    <= '0;
            l_q      <= '0;
            r_q      <= '0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            cnt_q    <= cnt_d;
            l_q      <= l_d;
            r_q      <= r_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk_audio) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= stereo_pcm;
        end
    end

    assign fifo_full = full_q;
    assign left      = left_q;
    assign right     = right_q;

endmodule

// File: tb/tb_audio_stereo_out.sv
module tb_audio_stereo_out;

    logic        clk_audio = 1'b0;
    logic        aclr = 1'b1;
    logic [15:0] stereo_pcm = '0;
    logic        stereo_pcm_rdy = 1'b0;
    logic        clk_pcm = 1'b0;
    logic        fifo_full;
    logic        left;
    logic        right;

    audio_stereo_out #(.PCM_W(8), .FIFO_DEPTH(16)) dut (
        .clk_audio      (clk_audio),
        .aclr           (aclr),
        .stereo_pcm     (stereo_pcm),
        .stereo_pcm_rdy (stereo_pcm_rdy),
        .clk_pcm        (clk_pcm),
        .fifo_full      (fifo_full),
        .left           (left),
        .right          (right)
    );

    // clock / reset
    always #5 clk_audio = ~clk_audio;

    int total = 0;
    int bad   = 0;

    // reference model: sample queue, current pair, frame position
    logic [15:0] exp_q[$];
    int m_cnt;
    int m_l;
    int m_r;
    int m_sync;
    bit exp_left;
    bit exp_right;
    bit exp_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_cnt = 0; m_l = 0; m_r = 0; m_sync = 0;
        exp_left = 0; exp_right = 0; exp_full = 0;
    endtask

    // One clock: advance model on the edge, then compare pins 1 time unit later.
    task automatic tick();
        logic        r;
        logic [15:0] d;
        logic [15:0] p;
        bit          do_pop;
        r = stereo_pcm_rdy;
        d = stereo_pcm;
        @(posedge clk_audio);
        if (!aclr) begin
            m_reset();
        end else if (m_sync < 2) begin
            m_sync++;
        end else begin
            exp_left  = (m_cnt < m_l);
            exp_right = (m_cnt < m_r);
            do_pop = (m_cnt == 255) && (exp_q.size() != 0);
            if (do_pop) begin
                p = exp_q.pop_front();
                m_l = int'(p[15:8]);
                m_r = int'(p[7:0]);
            end
            if (r && !exp_full) exp_q.push_back(d);
            m_cnt = (m_cnt + 1) % 256;
            exp_full = (exp_q.size() == 16);
        end
        #1;
        chk("left_pin", left, exp_left);
        chk("right_pin", right, exp_right);
        chk("fifo_full", fifo_full, exp_full);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_cnt(input int t);
        for (int k = 0; k < 600 && m_cnt != t; k++) tick();
    endtask

    task automatic push1(input logic [15:0] d);
        stereo_pcm = d;
        stereo_pcm_rdy = 1'b1;
        tick();
        stereo_pcm_rdy = 1'b0;
    endtask

    // high-time count over 256 consecutive clocks
    task automatic measure(output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            hl += int'(left);
            hr += int'(right);
        end
    endtask

    initial begin
        int hl;
        int hr;
        logic [15:0] v;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] pairs [3];

        m_reset();
        // reset
        #2 aclr = 1'b0;
        #1;
        chk("rst_left", left, 0);
        chk("rst_right", right, 0);
        chk("rst_full", fifo_full, 0);
        ticks(3);
        aclr = 1'b1;
        for (int f = 0; f < 3; f++) begin
            measure(hl, hr);
            chk("idle_left_duty", hl, 0);
            chk("idle_right_duty", hr, 0);
        end

        // single sample and underrun repeat
        push1({8'd127, 8'd0});
        ticks(2 * 256 + 4);
        measure(hl, hr);
        chk("l127_duty", hl, 127);
        chk("r0_duty", hr, 0);
        ticks(5 * 256);
        measure(hl, hr);
        chk("underrun_l_duty", hl, 127);
        chk("underrun_r_duty", hr, 0);

        // sequence of directed pairs
        pairs[0] = {8'd0, 8'd127};
        pairs[1] = {8'd127, 8'd127};
        pairs[2] = {8'd0, 8'd0};
        for (int i = 0; i < 3; i++) begin
            v = pairs[i];
            push1(v);
            ticks(9 * 256);
            measure(hl, hr);
            chk("seq_l_duty", hl, int'(v[15:8]));
            chk("seq_r_duty", hr, int'(v[7:0]));
        end

        // random pairs, including extremes through the value range
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom_range(0, 65535));
            if (i == 3) v = 16'hFF00;
            push1(v);
            ticks(2 * 256 + 4);
            measure(hl, hr);
            chk("rand_l_duty", hl, int'(v[15:8]));
            chk("rand_r_duty", hr, int'(v[7:0]));
        end

        // fill the FIFO back-to-back, overflow push dropped
        wait_cnt(1);
        stereo_pcm_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            stereo_pcm = {8'(i * 16 + 3), 8'(250 - i * 15)};
            tick();
        end
        chk("full_after_16", fifo_full, 1);
        stereo_pcm = 16'hABCD;
        tick();
        stereo_pcm_rdy = 1'b0;
        chk("full_after_17", fifo_full, 1);
        wait_cnt(0);
        chk("full_after_pop", fifo_full, 0);
        ticks(17 * 256);

        // push on the boundary cycle with one entry queued
        a = 16'($urandom_range(1, 65535));
        b = 16'($urandom_range(1, 65535));
        wait_cnt(100);
        push1(a);
        wait_cnt(255);
        push1(b);
        tick();
        measure(hl, hr);
        chk("bnd_a_l", hl, int'(a[15:8]));
        chk("bnd_a_r", hr, int'(a[7:0]));
        measure(hl, hr);
        chk("bnd_b_l", hl, int'(b[15:8]));
        chk("bnd_b_r", hr, int'(b[7:0]));

        // reset mid-frame with entries queued
        push1({8'd200, 8'd200});
        ticks(2 * 256 + 4);
        wait_cnt(2);
        stereo_pcm_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stereo_pcm = 16'($urandom_range(1, 65535));
            tick();
        end
        stereo_pcm_rdy = 1'b0;
        wait_cnt(100);
        chk("pre_rst_left_high", left, 1);
        aclr = 1'b0;
        #1;
        chk("mid_rst_left", left, 0);
        chk("mid_rst_right", right, 0);
        chk("mid_rst_full", fifo_full, 0);
        m_reset();
        ticks(3);
        aclr = 1'b1;
        ticks(3);
        chk("post_rst_full", fifo_full, 0);
        for (int f = 0; f < 2; f++) begin
            measure(hl, hr);
            chk("post_rst_l_duty", hl, 0);
            chk("post_rst_r_duty", hr, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
